// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling with 2-of-3 vote, start-glitch
// rejection, parity/frame error pulses and a valid/ready output with overrun.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] Rx_data,
  output logic                 Rx_valid,
  input  logic                 Rx_ready,
  output logic                 Frame_err,
  output logic                 Parity_err,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int unsigned DIV     = ((2 * CLK_FREQ) / (BAUD * 16) + 1) / 2;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic        PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic                 s7, s8;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr, ferr, armed;

  logic maj_c, res_c, wrap_c;
  logic start_det, shift_en, bit_clr, bit_inc, perr_set, ferr_set, done;
  logic ferr_now, data_load, valid_next, fe_next, pe_next, ov_next;

  assign maj_c  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign res_c  = tick && (tick_cnt == 4'd9);
  assign wrap_c = tick && (tick_cnt == 4'd15);

  // Input synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Free-running oversample divider
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && rx_prev && !rx_s) begin
          start_det  = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (res_c && maj_c) begin
          state_next = S_IDLE;
        end else if (wrap_c) begin
          bit_clr    = 1'b1;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        shift_en = res_c;
        if (wrap_c) begin
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_clr    = 1'b1;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        perr_set = res_c && ((^shift_reg) ^ maj_c ^ PAR_ODD);
        if (wrap_c) state_next = S_STOP;
      end
      S_STOP: begin
        // Last stop bit completes at its centre so back-to-back starts are seen
        if (res_c) begin
          ferr_set = !maj_c;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            done       = 1'b1;
            state_next = S_IDLE;
          end
        end else if (wrap_c) begin
          bit_inc = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Completion priority: frame error, then parity error, then deliver or overrun
  always_comb begin
    ferr_now   = ferr | ferr_set;
    valid_next = Rx_valid & ~Rx_ready;
    data_load  = 1'b0;
    fe_next    = 1'b0;
    pe_next    = 1'b0;
    ov_next    = 1'b0;
    if (done) begin
      if (ferr_now) begin
        fe_next = 1'b1;
        pe_next = perr;
      end else if (perr) begin
        pe_next = 1'b1;
      end else if (!Rx_valid || Rx_ready) begin
        data_load  = 1'b1;
        valid_next = 1'b1;
      end else begin
        ov_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt   <= '0;
      s7         <= 1'b1;
      s8         <= 1'b1;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      armed      <= 1'b0;
      Rx_data    <= '0;
      Rx_valid   <= 1'b0;
      Frame_err  <= 1'b0;
      Parity_err <= 1'b0;
      Overrun    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      if (start_det)  tick_cnt <= '0;
      else if (tick)  tick_cnt <= tick_cnt + 4'd1;

      if (tick && (tick_cnt == 4'd7)) s7 <= rx_s;
      if (tick && (tick_cnt == 4'd8)) s8 <= rx_s;

      if (start_det || bit_clr) bit_cnt <= '0;
      else if (bit_inc)         bit_cnt <= bit_cnt + 4'd1;

      if (shift_en) shift_reg <= {maj_c, shift_reg[DATA_BITS-1:1]};

      if (start_det)     perr <= 1'b0;
      else if (perr_set) perr <= 1'b1;
      if (start_det)     ferr <= 1'b0;
      else if (ferr_set) ferr <= 1'b1;

      // After a frame error the line must be seen idle before a new start
      if (done && ferr_now)  armed <= 1'b0;
      else if (tick && rx_s) armed <= 1'b1;

      if (data_load) Rx_data <= shift_reg;
      Rx_valid   <= valid_next;
      Frame_err  <= fe_next;
      Parity_err <= pe_next;
      Overrun    <= ov_next;
      Busy       <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7-bit even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BIT_NS = 8680;

  logic       Clk;
  logic       Reset;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] a_data;
  logic [6:0] b_data;
  logic       a_valid, a_fe, a_pe, a_ov, a_busy;
  logic       b_valid, b_fe, b_pe, b_ov, b_busy;

  int checks = 0;
  int errors = 0;
  int a_acc = 0, a_vcyc = 0, a_fe_n = 0, a_pe_n = 0, a_ov_n = 0;
  int b_acc = 0, b_vcyc = 0, b_fe_n = 0, b_pe_n = 0, b_ov_n = 0;
  logic [7:0] a_words [0:15];
  logic [6:0] b_last;

  uart_rx_param dut_a (
    .Clk(Clk), .Reset(Reset), .uart_rx(rx_a),
    .Rx_data(a_data), .Rx_valid(a_valid), .Rx_ready(ready_a),
    .Frame_err(a_fe), .Parity_err(a_pe), .Overrun(a_ov), .Busy(a_busy)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .uart_rx(rx_b),
    .Rx_data(b_data), .Rx_valid(b_valid), .Rx_ready(ready_b),
    .Frame_err(b_fe), .Parity_err(b_pe), .Overrun(b_ov), .Busy(b_busy)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Output monitor sampled on the falling edge
  always @(negedge Clk) begin
    if (!Reset) begin
      if (a_valid) a_vcyc++;
      if (a_valid && ready_a) begin
        if (a_acc < 16) a_words[a_acc] = a_data;
        a_acc++;
      end
      if (a_fe) a_fe_n++;
      if (a_pe) a_pe_n++;
      if (a_ov) a_ov_n++;
      if (b_valid) b_vcyc++;
      if (b_valid && ready_b) begin
        b_last = b_data;
        b_acc++;
      end
      if (b_fe) b_fe_n++;
      if (b_pe) b_pe_n++;
      if (b_ov) b_ov_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input int nbits,
                      input int par, input logic stop_v);
    set_line(sel, 1'b0);
    #BIT_NS;
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, d[i]);
      #BIT_NS;
    end
    if (par >= 0) begin
      set_line(sel, par[0]);
      #BIT_NS;
    end
    set_line(sel, stop_v);
    #BIT_NS;
    set_line(sel, 1'b1);
  endtask

  initial begin
    logic [7:0] sb;
    Reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    #5;
    check("rst_data",  32'(a_data), 32'h0);
    check("rst_valid", 32'(a_valid), 32'h0);
    check("rst_busy",  32'(a_busy), 32'h0);
    check("rst_pulses", 32'({a_fe, a_pe, a_ov}), 32'h0);
    #95 Reset = 1'b0;
    #(2*BIT_NS);

    // Two back-to-back 8N1 frames
    send(0, 8'h55, 8, -1, 1'b1);
    send(0, 8'hA5, 8, -1, 1'b1);
    #(2*BIT_NS);
    check("b2b_count", 32'(a_acc), 32'd2);
    check("b2b_word0", 32'(a_words[0]), 32'h55);
    check("b2b_word1", 32'(a_words[1]), 32'hA5);
    check("b2b_vcycles", 32'(a_vcyc), 32'd2);
    check("b2b_errs", 32'(a_fe_n + a_pe_n + a_ov_n), 32'd0);

    // 0x12 with data bit 1 cut to a tenth: later bits slide one slot early -> 0x88
    sb = 8'h12;
    rx_a = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx_a = sb[i];
      if (i == 1) #868;
      else        #BIT_NS;
    end
    rx_a = 1'b1;
    #(2*BIT_NS);
    check("short_count", 32'(a_acc), 32'd3);
    check("short_word", 32'(a_words[2]), 32'h88);
    check("short_busy", 32'(a_busy), 32'h0);
    check("short_errs", 32'(a_fe_n + a_pe_n + a_ov_n), 32'd0);

    // Start glitch shorter than half a bit
    rx_a = 1'b0;
    #1000;
    check("glitch_busy_hi", 32'(a_busy), 32'h1);
    #1000 rx_a = 1'b1;
    #BIT_NS;
    check("glitch_busy_lo", 32'(a_busy), 32'h0);
    check("glitch_count", 32'(a_acc), 32'd3);
    check("glitch_errs", 32'(a_fe_n + a_pe_n + a_ov_n), 32'd0);

    // 7E1: 0x34 has three ones, so the even parity bit is 1
    send(1, 8'h34, 7, 1, 1'b1);
    #(2*BIT_NS);
    check("par_ok_count", 32'(b_acc), 32'd1);
    check("par_ok_word", 32'(b_last), 32'h34);
    check("par_ok_perr", 32'(b_pe_n), 32'd0);
    send(1, 8'h34, 7, 0, 1'b1);
    #(2*BIT_NS);
    check("par_bad_perr", 32'(b_pe_n), 32'd1);
    check("par_bad_vcyc", 32'(b_vcyc), 32'd1);
    check("par_bad_busy", 32'(b_busy), 32'h0);
    check("par_bad_other", 32'(b_fe_n + b_ov_n), 32'd0);

    // Low stop bit followed by a long break, then a clean frame
    send(0, 8'h00, 8, -1, 1'b0);
    rx_a = 1'b0;
    #(50*BIT_NS);
    rx_a = 1'b1;
    #(2*BIT_NS);
    send(0, 8'h9A, 8, -1, 1'b1);
    #(2*BIT_NS);
    check("break_ferr", 32'(a_fe_n), 32'd1);
    check("break_perr", 32'(a_pe_n), 32'd0);
    check("break_count", 32'(a_acc), 32'd4);
    check("break_word", 32'(a_words[3]), 32'h9A);

    // Overrun with the consumer stalled
    ready_a = 1'b0;
    send(0, 8'h56, 8, -1, 1'b1);
    send(0, 8'h78, 8, -1, 1'b1);
    #(2*BIT_NS);
    check("ovr_valid", 32'(a_valid), 32'h1);
    check("ovr_data", 32'(a_data), 32'h56);
    check("ovr_pulses", 32'(a_ov_n), 32'd1);
    @(posedge Clk);
    #1 ready_a = 1'b1;
    @(posedge Clk);
    #1;
    check("ovr_drain_valid", 32'(a_valid), 32'h0);
    check("ovr_drain_word", 32'(a_words[4]), 32'h56);

    // Reset in the middle of 0xF0 (line low during data bit 3)
    rx_a = 1'b0;
    #(4*BIT_NS + BIT_NS/2);
    check("mid_busy", 32'(a_busy), 32'h1);
    Reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(a_data), 32'h0);
    check("mid_rst_busy", 32'(a_busy), 32'h0);
    check("mid_rst_pulses", 32'({a_valid, a_fe, a_pe, a_ov}), 32'h0);
    rx_a = 1'b1;
    #200 Reset = 1'b0;
    #(2*BIT_NS);
    send(0, 8'hF0, 8, -1, 1'b1);
    #(2*BIT_NS);
    check("post_rst_count", 32'(a_acc), 32'd6);
    check("post_rst_word", 32'(a_words[5]), 32'hF0);
    check("post_rst_data", 32'(a_data), 32'hF0);
    check("post_rst_errs", 32'(a_fe_n + a_pe_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
